// File: rtl/aes_in_pkg.sv
// Shared types and sizing for the AES input loader.
package aes_in_pkg;
  localparam int WORDS_PER_BLOCK    = 4;
  localparam int WORD_W             = 32;
  localparam int BLK_W              = WORDS_PER_BLOCK * WORD_W;
  localparam int WC_W               = $clog2(WORDS_PER_BLOCK);
  localparam int TIMEOUT_CYCLES_DEF = 255;

  typedef enum logic [1:0] {ST_KEY, ST_DATA, ST_RUN} aes_st_e;
endpackage

// File: rtl/aes_word_packer.sv
// Packs 32-bit words MSW-first into a 128-bit register; clr zeroes the block.
module aes_word_packer
  import aes_in_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic              clr,
  input  logic [WORD_W-1:0] wdata,
  output logic [BLK_W-1:0]  blk,
  output logic              last
);
  logic [WC_W-1:0] wc;

  assign last = wr_en && (wc == WC_W'(WORDS_PER_BLOCK - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      blk <= '0;
      wc  <= '0;
    end else if (clr) begin
      blk <= '0;
    end else if (wr_en) begin
      for (int i = 0; i < WORDS_PER_BLOCK; i++)
        if (wc == WC_W'(i)) blk[BLK_W-1-WORD_W*i -: WORD_W] <= wdata;
      wc <= wc + 1'b1;
    end
  end
endmodule

// File: rtl/aes_in_loader.sv
// Feeds AES_top: loads key/plaintext words, runs the core, times out if it stalls.
// Optional macro AES_IN_SCRUB_EN clears operand registers when a block leaves RUN.
module aes_in_loader
  import aes_in_pkg::*;
#(
  parameter  int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
  localparam int CNT_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic              AES_clk,
  input  logic              AES_rst_n,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [WORD_W-1:0] s_data,
  input  logic              cfg_key_reuse,
  input  logic              AES_data_out_valid,
  output logic              AES_en,
  output logic [BLK_W-1:0]  AES_key_in,
  output logic [BLK_W-1:0]  AES_data_in,
  output logic              busy,
  output logic              blk_done,
  output logic              timeout_err
);
  aes_st_e          state;
  logic [CNT_W-1:0] run_cnt;
  logic             xfer, key_wr, data_wr, key_last, data_last;
  logic             run_exit, key_clr, data_clr;

  assign xfer     = s_valid && s_ready;
  assign key_wr   = xfer && (state == ST_KEY);
  assign data_wr  = xfer && (state == ST_DATA);
  // Completion and timeout share one exit; completion takes precedence below.
  assign run_exit = (state == ST_RUN) &&
                    (AES_data_out_valid || (run_cnt == CNT_W'(TIMEOUT_CYCLES)));

`ifdef AES_IN_SCRUB_EN
  assign data_clr = run_exit;
  assign key_clr  = run_exit && !cfg_key_reuse;
`else
  assign data_clr = 1'b0;
  assign key_clr  = 1'b0;
`endif

  aes_word_packer u_key (
    .clk(AES_clk), .rst_n(AES_rst_n), .wr_en(key_wr), .clr(key_clr),
    .wdata(s_data), .blk(AES_key_in), .last(key_last)
  );

  aes_word_packer u_data (
    .clk(AES_clk), .rst_n(AES_rst_n), .wr_en(data_wr), .clr(data_clr),
    .wdata(s_data), .blk(AES_data_in), .last(data_last)
  );

  always_ff @(posedge AES_clk) begin
    if (!AES_rst_n) begin
      state       <= ST_KEY;
      run_cnt     <= '0;
      s_ready     <= 1'b0;
      AES_en      <= 1'b0;
      busy        <= 1'b0;
      blk_done    <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      blk_done <= 1'b0;
      case (state)
        ST_KEY: begin
          s_ready <= 1'b1;
          if (key_last) state <= ST_DATA;
        end
        ST_DATA: begin
          s_ready <= 1'b1;
          if (data_last) begin
            state   <= ST_RUN;
            s_ready <= 1'b0;
            AES_en  <= 1'b1;
            busy    <= 1'b1;
            run_cnt <= '0;
          end
        end
        ST_RUN: begin
          if (run_exit) begin
            state   <= cfg_key_reuse ? ST_DATA : ST_KEY;
            s_ready <= 1'b1;
            AES_en  <= 1'b0;
            busy    <= 1'b0;
            run_cnt <= '0;
            if (AES_data_out_valid) blk_done    <= 1'b1;
            else                    timeout_err <= 1'b1;
          end else begin
            run_cnt <= run_cnt + 1'b1;
          end
        end
        default: begin
          state   <= ST_KEY;
          s_ready <= 1'b1;
          AES_en  <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_aes_in_loader.sv
// Bench for aes_in_loader: two instances (default and 8-cycle timeout) share stimulus.
module tb_aes_in_loader;
  import aes_in_pkg::*;

  localparam int TO_A = TIMEOUT_CYCLES_DEF;
  localparam int TO_B = 8;

  logic         AES_clk = 1'b0;
  logic         AES_rst_n = 1'b0;
  logic         s_valid = 1'b0;
  logic [31:0]  s_data = '0;
  logic         cfg_key_reuse = 1'b0;
  logic         AES_data_out_valid = 1'b0;

  logic         s_ready, AES_en, busy, blk_done, timeout_err;
  logic [127:0] AES_key_in, AES_data_in;
  logic         s_ready8, AES_en8, busy8, blk_done8, timeout_err8;
  logic [127:0] AES_key_in8, AES_data_in8;

  always #5 AES_clk = ~AES_clk;

  aes_in_loader u_dut (
    .AES_clk(AES_clk), .AES_rst_n(AES_rst_n), .s_valid(s_valid), .s_ready(s_ready),
    .s_data(s_data), .cfg_key_reuse(cfg_key_reuse), .AES_data_out_valid(AES_data_out_valid),
    .AES_en(AES_en), .AES_key_in(AES_key_in), .AES_data_in(AES_data_in), .busy(busy),
    .blk_done(blk_done), .timeout_err(timeout_err)
  );

  aes_in_loader #(.TIMEOUT_CYCLES(TO_B)) u_dut8 (
    .AES_clk(AES_clk), .AES_rst_n(AES_rst_n), .s_valid(s_valid), .s_ready(s_ready8),
    .s_data(s_data), .cfg_key_reuse(cfg_key_reuse), .AES_data_out_valid(AES_data_out_valid),
    .AES_en(AES_en8), .AES_key_in(AES_key_in8), .AES_data_in(AES_data_in8), .busy(busy8),
    .blk_done(blk_done8), .timeout_err(timeout_err8)
  );

  int n_chk = 0, n_fail = 0;
  int en_a = 0, en_b = 0, dn_a = 0, dn_b = 0, bad = 0;
  logic [127:0] m_key = '0, m_data = '0;
  bit m_to_a = 1'b0, m_to_b = 1'b0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Cycle-level observation away from the active edge
  always @(negedge AES_clk) begin
    if (AES_en)    en_a++;
    if (AES_en8)   en_b++;
    if (blk_done)  dn_a++;
    if (blk_done8) dn_b++;
    if ((AES_en && s_ready) || (AES_en8 && s_ready8) || (busy != AES_en) || (busy8 != AES_en8))
      bad++;
  end

  task automatic tick();
    @(posedge AES_clk);
    #1;
  endtask

  task automatic do_reset();
    AES_rst_n = 1'b0; s_valid = 1'b0; AES_data_out_valid = 1'b0;
    tick();
    chk("rst_ctl_a", 128'({s_ready, AES_en, busy, blk_done, timeout_err}), '0);
    chk("rst_ctl_b", 128'({s_ready8, AES_en8, busy8, blk_done8, timeout_err8}), '0);
    chk("rst_key", AES_key_in | AES_key_in8, '0);
    chk("rst_data", AES_data_in | AES_data_in8, '0);
    AES_rst_n = 1'b1;
    m_key = '0; m_data = '0; m_to_a = 1'b0; m_to_b = 1'b0;
    tick();
    chk("rst_ready", 128'({s_ready, s_ready8}), 128'(2'b11));
  endtask

  task automatic send_word(input logic [31:0] w);
    int g;
    g = 0;
    while (!(s_ready && s_ready8) && g < 400) begin
      tick();
      g++;
    end
    chk("ready_wait", 128'(s_ready && s_ready8), 128'(1));
    repeat ($urandom_range(0, 2)) tick();
    s_valid = 1'b1; s_data = w;
    tick();
    s_valid = 1'b0; s_data = $urandom;
  endtask

  task automatic load(input bit do_key, input logic [127:0] key, input logic [127:0] data);
    if (do_key) begin
      for (int i = 0; i < 4; i++) send_word(key[127-32*i -: 32]);
      m_key = key;
    end
    for (int i = 0; i < 4; i++) send_word(data[127-32*i -: 32]);
    m_data = data;
  endtask

  // Called just after the edge that took the last data word. Valid is raised
  // d cycles after AES_en rises, so it is sampled on the (d+1)th edge of RUN.
  task automatic run_block(input int d, input bit reuse);
    int ea, eb, da, db, k, xa, xb;
    bit ok_a, ok_b;
    ea = en_a; eb = en_b; da = dn_a; db = dn_b;
    k = d + 1;
    chk("en_rise", 128'({AES_en, AES_en8}), 128'(2'b11));
    chk("rdy_low", 128'({s_ready, s_ready8}), '0);
    chk("key_a", AES_key_in, m_key);
    chk("data_a", AES_data_in, m_data);
    chk("key_b", AES_key_in8, m_key);
    chk("data_b", AES_data_in8, m_data);
    cfg_key_reuse = reuse;
    s_valid = 1'b1; s_data = $urandom;
    repeat (3) tick();
    s_valid = 1'b0;
    chk("frozen_key", AES_key_in, m_key);
    chk("frozen_data", AES_data_in, m_data);
    repeat (d - 3) tick();
    AES_data_out_valid = 1'b1;
    tick();
    AES_data_out_valid = 1'b0;
    ok_a = (k <= TO_A + 1);
    ok_b = (k <= TO_B + 1);
`ifdef AES_IN_SCRUB_EN
    m_data = '0;
    if (!reuse) m_key = '0;
`endif
    chk("en_fall", 128'(AES_en), '0);
    chk("done_pulse", 128'(blk_done), 128'(ok_a));
    chk("data_exit", AES_data_in, m_data);
    repeat (2) tick();
    chk("done_low", 128'({blk_done, blk_done8}), '0);
    xa = ok_a ? k : TO_A + 1;
    xb = ok_b ? k : TO_B + 1;
    chk("en_cycles_a", 128'(en_a - ea), 128'(xa));
    chk("en_cycles_b", 128'(en_b - eb), 128'(xb));
    chk("done_cnt_a", 128'(dn_a - da), 128'(ok_a));
    chk("done_cnt_b", 128'(dn_b - db), 128'(ok_b));
    m_to_a = m_to_a | !ok_a;
    m_to_b = m_to_b | !ok_b;
    chk("to_err_a", 128'(timeout_err), 128'(m_to_a));
    chk("to_err_b", 128'(timeout_err8), 128'(m_to_b));
    chk("post_key_a", AES_key_in, m_key);
    chk("post_key_b", AES_key_in8, m_key);
    chk("post_data_b", AES_data_in8, m_data);
    chk("rdy_back", 128'({s_ready, s_ready8}), 128'(2'b11));
    chk("rdy_vs_en", 128'(bad), '0);
    cfg_key_reuse = 1'b0;
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int d0, d;
    bit reuse, prev_reuse;
    do_reset();

    // Completion strobe while idle must be ignored
    d0 = dn_a + dn_b;
    AES_data_out_valid = 1'b1; tick(); AES_data_out_valid = 1'b0;
    repeat (2) tick();
    chk("valid_idle_done", 128'(dn_a + dn_b - d0), '0);
    chk("valid_idle_en", 128'({AES_en, AES_en8}), '0);

    // Directed block; the 8-cycle instance times out on it
    load(1'b1, 128'haa2bdb40_bff6a5e8_caa9ba3e_bc1e2acc, 128'h0000001f_00000000_00000000_00000000);
    chk("plan_key", AES_key_in, 128'haa2bdb40_bff6a5e8_caa9ba3e_bc1e2acc);
    chk("plan_data", AES_data_in, 128'h0000001f_00000000_00000000_00000000);
    run_block(50, 1'b0);

    // Key reuse: only data words follow
    load(1'b1, rnd128(), rnd128());
    run_block(30, 1'b1);
    load(1'b0, m_key, 128'ha6f2daeb_140fa720_529e75d5_21cbc681);
    chk("reuse_data", AES_data_in, 128'ha6f2daeb_140fa720_529e75d5_21cbc681);
    run_block(20, 1'b0);

    prev_reuse = 1'b0;
    for (int b = 0; b < 6; b++) begin
      case ($urandom_range(0, 3))
        0: d = 7;
        1: d = 8;
        2: d = 9;
        default: d = $urandom_range(10, 120);
      endcase
      reuse = 1'($urandom_range(0, 1));
      load(!prev_reuse, rnd128(), rnd128());
      run_block(d, reuse);
      prev_reuse = reuse;
    end

    // Completion exactly when the short counter hits its limit
    do_reset();
    load(1'b1, rnd128(), rnd128());
    run_block(8, 1'b0);
    chk("boundary_no_to", 128'(timeout_err8), '0);

    // Reset after two data words
    for (int i = 0; i < 4; i++) send_word($urandom);
    send_word($urandom);
    send_word($urandom);
    do_reset();
    load(1'b1, rnd128(), rnd128());
    run_block(20, 1'b0);

    // Reset during RUN
    load(1'b1, rnd128(), rnd128());
    repeat (5) tick();
    do_reset();
    load(1'b1, rnd128(), rnd128());
    run_block(15, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
